// File: rtl/spi_slave_port.sv
// SPI slave endpoint (CPOL=0, CPHA=1, MSB first), fully synchronous to clk.
// sclk/cs/mosi are oversampled through synchronizers; one full-duplex word per cs-low frame.
module spi_slave_port #(
   parameter int DATA_WIDTH  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  valid,
   output logic                  aborted,
   output logic                  ready,
   input  logic                  mosi,
   output logic                  miso,
   input  logic                  sclk,
   input  logic                  cs
);
   localparam int CNT_W   = $clog2(DATA_WIDTH + 1);
   localparam int FLUSH_W = $clog2(SYNC_STAGES + 2);
   localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
   localparam logic [FLUSH_W-1:0] FLUSH_END = FLUSH_W'(SYNC_STAGES + 1);

   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, WAIT_CS = 2'd2} state_t;

   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  sclk_sync_q, cs_sync_q, mosi_sync_q;
   logic                    sclk_prev_q, cs_prev_q;
   logic [FLUSH_W-1:0]      flush_q, flush_d;
   logic [DATA_WIDTH-1:0]   tx_sh_q, tx_sh_d;
   logic [DATA_WIDTH-1:0]   rx_sh_q, rx_sh_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic [CNT_W-1:0]        bit_cnt_q, bit_cnt_d;
   logic                    valid_q, valid_d;
   logic                    aborted_q, aborted_d;
   logic                    ready_q, ready_d;
   logic                    miso_q, miso_d;
   logic                    s_sclk, s_cs, s_mosi;
   logic                    sclk_rise, sclk_fall, cs_rise, cs_fall;
   logic [DATA_WIDTH-1:0]   rx_next;

   assign s_sclk    = sclk_sync_q[SYNC_STAGES-1];
   assign s_cs      = cs_sync_q[SYNC_STAGES-1];
   assign s_mosi    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = s_sclk & ~sclk_prev_q;
   assign sclk_fall = ~s_sclk & sclk_prev_q;
   assign cs_rise   = s_cs & ~cs_prev_q;
   assign cs_fall   = ~s_cs & cs_prev_q;
   assign rx_next   = {rx_sh_q[DATA_WIDTH-2:0], s_mosi};

   // Next-state and datapath decisions for the frame FSM
   always_comb begin
      state_d    = state_q;
      tx_sh_d    = tx_sh_q;
      rx_sh_d    = rx_sh_q;
      data_out_d = data_out_q;
      bit_cnt_d  = bit_cnt_q;
      miso_d     = miso_q;
      valid_d    = 1'b0;
      aborted_d  = 1'b0;
      // The synchronizers refill after reset; edges seen while they flush are not real.
      if (flush_q == FLUSH_END) begin
         flush_d = flush_q;
      end else begin
         flush_d = flush_q + FLUSH_W'(1);
      end
      case (state_q)
         IDLE: begin
            miso_d = 1'b0;
            if (flush_q != FLUSH_END) begin
               state_d = IDLE;
            end else if (cs_fall) begin
               tx_sh_d   = data_in;
               rx_sh_d   = '0;
               bit_cnt_d = '0;
               state_d   = ACTIVE;
            end else if (!s_cs) begin
               state_d = WAIT_CS;
            end else begin
               state_d = IDLE;
            end
         end
         ACTIVE: begin
            // A completing fall takes priority over a cs rise in the same cycle.
            if (sclk_fall && (bit_cnt_q == LAST_BIT)) begin
               rx_sh_d    = rx_next;
               bit_cnt_d  = bit_cnt_q + CNT_W'(1);
               data_out_d = rx_next;
               valid_d    = 1'b1;
               state_d    = WAIT_CS;
            end else if (cs_rise) begin
               aborted_d = 1'b1;
               miso_d    = 1'b0;
               state_d   = IDLE;
            end else if (sclk_rise) begin
               miso_d  = tx_sh_q[DATA_WIDTH-1];
               tx_sh_d = {tx_sh_q[DATA_WIDTH-2:0], 1'b0};
            end else if (sclk_fall) begin
               rx_sh_d   = rx_next;
               bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
               state_d = ACTIVE;
            end
         end
         WAIT_CS: begin
            if (cs_rise) begin
               miso_d  = 1'b0;
               state_d = IDLE;
            end else begin
               state_d = WAIT_CS;
            end
         end
         default: begin
            miso_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == IDLE);
   end

   // State, synchronizer and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         cs_sync_q   <= '1;
         mosi_sync_q <= '0;
         sclk_prev_q <= 1'b0;
         cs_prev_q   <= 1'b1;
         flush_q     <= '0;
         state_q     <= IDLE;
         tx_sh_q     <= '0;
         rx_sh_q     <= '0;
         data_out_q  <= '0;
         bit_cnt_q   <= '0;
         valid_q     <= 1'b0;
         aborted_q   <= 1'b0;
         ready_q     <= 1'b1;
         miso_q      <= 1'b0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
         sclk_prev_q <= s_sclk;
         cs_prev_q   <= s_cs;
         flush_q     <= flush_d;
         state_q     <= state_d;
         tx_sh_q     <= tx_sh_d;
         rx_sh_q     <= rx_sh_d;
         data_out_q  <= data_out_d;
         bit_cnt_q   <= bit_cnt_d;
         valid_q     <= valid_d;
         aborted_q   <= aborted_d;
         ready_q     <= ready_d;
         miso_q      <= miso_d;
      end
   end

   assign data_out = data_out_q;
   assign valid    = valid_q;
   assign aborted  = aborted_q;
   assign ready    = ready_q;
   assign miso     = miso_q;

endmodule

// File: tb/tb_spi_slave_port.sv
// Scoreboard bench for spi_slave_port: a behavioural SPI master drives frames,
// expected events are queued at issue time and a monitor checks them as they appear.
module tb_spi_slave_port;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, mosi, sclk, cs;
   logic         miso, valid, aborted, ready;
   logic [W-1:0] data_in, data_out;

   always #5 clk = ~clk;

   spi_slave_port #(.DATA_WIDTH(W), .SYNC_STAGES(2)) dut (
      .clk(clk), .rst(rst), .data_in(data_in), .data_out(data_out),
      .valid(valid), .aborted(aborted), .ready(ready),
      .mosi(mosi), .miso(miso), .sclk(sclk), .cs(cs)
   );

   typedef struct packed {
      logic         is_abort;
      logic [W-1:0] data;
   } ev_t;

   ev_t          exp_q[$];
   logic [W-1:0] miso_exp_q[$];
   logic [W-1:0] miso_obs_q[$];
   logic [W-1:0] last_word = '0;
   ev_t          mon_e;
   int           n_checks = 0;
   int           n_pass = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Monitor: every valid/aborted pulse must match the oldest queued expectation
   always @(negedge clk) begin
      if (valid === 1'b1 || aborted === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", 32'({valid, aborted}), 32'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("event_kind", 32'({valid, aborted}), mon_e.is_abort ? 32'd1 : 32'd2);
            check("data_out", 32'(data_out), 32'(mon_e.data));
         end
      end
      if (miso_obs_q.size() != 0 && miso_exp_q.size() != 0)
         check("miso_word", 32'(miso_obs_q.pop_front()), 32'(miso_exp_q.pop_front()));
   end

   // One cs-low frame of nbits sclk pulses; bits are sent MSB first from bit nbits-1.
   // rst_after>0 pulses rst after that many bits with cs still low.
   task automatic run_frame(input logic [W-1:0] din, input logic [15:0] bits, input int nbits,
                            input int h, input int gap, input int rst_after);
      logic [15:0] sh;
      logic [W-1:0] rd;
      ev_t e;
      rd = '0;
      if (rst_after == 0) begin
         if (nbits >= W) begin
            sh = bits >> (nbits - W);
            e.is_abort = 1'b0;
            e.data = sh[W-1:0];
            last_word = sh[W-1:0];
            miso_exp_q.push_back(din);
         end else begin
            e.is_abort = 1'b1;
            e.data = last_word;
         end
         exp_q.push_back(e);
      end
      data_in = din;
      wait_clk(2);
      cs = 1'b0;
      wait_clk(h);
      for (int i = 0; i < nbits; i++) begin
         sclk = 1'b1;
         mosi = bits[nbits-1-i];
         wait_clk(h);
         sclk = 1'b0;
         if (i < W) rd = {rd[W-2:0], miso};
         wait_clk(h);
         if (i + 1 == rst_after) begin
            rst = 1'b1;
            wait_clk(2);
            rst = 1'b0;
            last_word = '0;
            wait_clk(10);
            check("ready_low_after_midframe_rst", 32'(ready), 32'd0);
            check("data_out_cleared", 32'(data_out), 32'd0);
         end
      end
      data_in = W'($urandom());
      cs = 1'b1;
      if (rst_after == 0 && nbits >= W) miso_obs_q.push_back(rd);
      wait_clk(gap);
      check("ready_after_cs_high", 32'(ready), 32'd1);
   endtask

   initial begin
      rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; data_in = '0;
      wait_clk(3);
      rst = 1'b0;
      wait_clk(1);
      check("rst_data_out", 32'(data_out), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_aborted", 32'(aborted), 32'd0);
      check("rst_miso", 32'(miso), 32'd0);
      check("rst_ready", 32'(ready), 32'd1);
      wait_clk(4);

      run_frame(8'hA5, 16'h003C, 8, 6, 8, 0);
      run_frame(8'h5C, 16'h0001, 8, 6, 8, 0);
      run_frame(8'hE7, 16'h00FF, 8, 6, 8, 0);
      run_frame(8'h33, 16'h0015, 5, 6, 8, 0);
      run_frame(8'h69, 16'h005A, 8, 6, 8, 0);
      run_frame(8'h7E, {6'd0, 8'hC3, 2'b10}, 10, 6, 8, 0);
      run_frame(8'h11, 16'h0077, 8, 6, 8, 3);
      run_frame(8'hB4, 16'h0096, 8, 6, 8, 0);

      for (int k = 0; k < 10; k++) begin
         int nb;
         nb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(10, 0)) : W;
         run_frame(W'($urandom()), 16'($urandom()), nb,
                   int'($urandom_range(8, 5)), int'($urandom_range(10, 6)), 0);
      end

      wait_clk(20);
      check("pending_events", 32'(exp_q.size()), 32'd0);
      check("pending_miso", 32'(miso_exp_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
